dis_ram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one dispatcher two-port RAM (one write port, one read port, registered read) among NUM_REQ requesters. Each port has its own independent arbiter. Read responses come back one cycle after grant, tagged with the requester ID. The block sits between dispatcher clients (allocators, resource tables) and a single RAM instance, and drives that RAM's write and read ports directly.

---
 rtl/dis_ram_port_arbiter_pkg.sv | 21 ++
 rtl/dis_ram_port_arbiter_rr_arbiter.sv | 43 ++++
 rtl/dis_ram_port_arbiter.sv | 93 +++++++++
 tb/tb_dis_ram_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dis_ram_port_arbiter_pkg.sv
// Shared dispatcher RAM-arbiter definitions: default geometry, the flat-bus slice macro
// and the modulo pointer increment used by the round-robin arbiters.
`ifndef DIS_RAM_PORT_ARBITER_PKG_SV
`define DIS_RAM_PORT_ARBITER_PKG_SV

`define DIS_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package dis_ram_port_arbiter_pkg;

    localparam int DIS_NUM_REQ   = 4;
    localparam int DIS_REQ_ID_W  = 2;
    localparam int DIS_WORD_SIZE = 16;
    localparam int DIS_ADDR_SIZE = 5;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

`endif

// File: rtl/dis_ram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter with combinational one-hot grant; the pointer moves to one past
// the last granted requester and holds when nobody requests.
module rr_arbiter
    import dis_ram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DIS_NUM_REQ,
    parameter int REQ_ID_W = DIS_REQ_ID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [REQ_ID_W-1:0] gnt_id
);

    logic [REQ_ID_W-1:0] ptr;

    always_comb begin
        int idx;
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = int'(ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = REQ_ID_W'(idx);
                found    = 1'b1;
            end
            idx = wrap_inc(idx, NUM_REQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (|req) begin
            ptr <= REQ_ID_W'(wrap_inc(int'(gnt_id), NUM_REQ));
        end
    end

endmodule

// File: rtl/dis_ram_port_arbiter.sv
// Shares one registered-read two-port dispatcher RAM among NUM_REQ clients with independent
// write/read round-robin arbiters. Define RAM_ARB_WR_BYPASS_EN to forward same-address writes to reads.
module dis_ram_port_arbiter
    import dis_ram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DIS_NUM_REQ,
    parameter int REQ_ID_W  = DIS_REQ_ID_W,
    parameter int WORD_SIZE = DIS_WORD_SIZE,
    parameter int ADDR_SIZE = DIS_ADDR_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            wr_req,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]  wr_addr_flat,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  wr_word_flat,
    output logic [NUM_REQ-1:0]            wr_gnt,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]  rd_addr_flat,
    output logic [NUM_REQ-1:0]            rd_gnt,
    output logic                          rd_valid,
    output logic [REQ_ID_W-1:0]           rd_id,
    output logic [WORD_SIZE-1:0]          rd_data,
    output logic                          ram_wr_en,
    output logic [ADDR_SIZE-1:0]          ram_wr_addr,
    output logic [WORD_SIZE-1:0]          ram_wr_word,
    output logic                          ram_rd_en,
    output logic [ADDR_SIZE-1:0]          ram_rd_addr,
    input  logic [WORD_SIZE-1:0]          ram_rd_word
);

    logic [REQ_ID_W-1:0] wr_id_p0;
    logic [REQ_ID_W-1:0] rd_id_p0;
    logic                vld_p1;
    logic [REQ_ID_W-1:0] id_p1;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_ID_W(REQ_ID_W)) u_wr_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (wr_req),
        .gnt    (wr_gnt),
        .gnt_id (wr_id_p0)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_ID_W(REQ_ID_W)) u_rd_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (rd_req),
        .gnt    (rd_gnt),
        .gnt_id (rd_id_p0)
    );

    // Stage p0: grant-selected RAM port drive
    assign ram_wr_en   = |wr_gnt;
    assign ram_wr_addr = ram_wr_en ? `DIS_SLICE(wr_addr_flat, int'(wr_id_p0), ADDR_SIZE) : '0;
    assign ram_wr_word = ram_wr_en ? `DIS_SLICE(wr_word_flat, int'(wr_id_p0), WORD_SIZE) : '0;
    assign ram_rd_en   = |rd_gnt;
    assign ram_rd_addr = ram_rd_en ? `DIS_SLICE(rd_addr_flat, int'(rd_id_p0), ADDR_SIZE) : '0;

    // Stage p1: response tag aligned with the RAM's registered read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
        end else begin
            vld_p1 <= ram_rd_en;
            id_p1  <= rd_id_p0;
        end
    end

    assign rd_valid = vld_p1;
    assign rd_id    = id_p1;

`ifdef RAM_ARB_WR_BYPASS_EN
    logic                 byp_p1;
    logic [WORD_SIZE-1:0] byp_word_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_p1      <= 1'b0;
            byp_word_p1 <= '0;
        end else begin
            byp_p1      <= ram_wr_en && ram_rd_en && (ram_wr_addr == ram_rd_addr);
            byp_word_p1 <= ram_wr_word;
        end
    end

    assign rd_data = byp_p1 ? byp_word_p1 : ram_rd_word;
`else
    // RAM reads before it writes, so a same-address collision returns the old word.
    assign rd_data = ram_rd_word;
`endif

endmodule

// File: tb/tb_dis_ram_port_arbiter.sv
// Directed bench for dis_ram_port_arbiter with a behavioural registered-read RAM and a
// read-response scoreboard; expected bypass behaviour follows RAM_ARB_WR_BYPASS_EN.
module tb_dis_ram_port_arbiter;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int WS = 16;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    wr_req, rd_req;
    logic [AW-1:0]    wr_addr [NR];
    logic [AW-1:0]    rd_addr [NR];
    logic [WS-1:0]    wr_word [NR];
    logic [NR*AW-1:0] wr_addr_flat, rd_addr_flat;
    logic [NR*WS-1:0] wr_word_flat;
    logic [NR-1:0]    wr_gnt, rd_gnt;
    logic             rd_valid;
    logic [IW-1:0]    rd_id;
    logic [WS-1:0]    rd_data;
    logic             ram_wr_en, ram_rd_en;
    logic [AW-1:0]    ram_wr_addr, ram_rd_addr;
    logic [WS-1:0]    ram_wr_word, ram_rd_word;

    always_comb begin
        wr_addr_flat = '0;
        rd_addr_flat = '0;
        wr_word_flat = '0;
        for (int i = 0; i < NR; i++) begin
            wr_addr_flat[i*AW +: AW] = wr_addr[i];
            rd_addr_flat[i*AW +: AW] = rd_addr[i];
            wr_word_flat[i*WS +: WS] = wr_word[i];
        end
    end

    dis_ram_port_arbiter #(.NUM_REQ(NR), .REQ_ID_W(IW), .WORD_SIZE(WS), .ADDR_SIZE(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .wr_addr_flat (wr_addr_flat),
        .wr_word_flat (wr_word_flat),
        .wr_gnt       (wr_gnt),
        .rd_req       (rd_req),
        .rd_addr_flat (rd_addr_flat),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .rd_id        (rd_id),
        .rd_data      (rd_data),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_word  (ram_wr_word),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_word  (ram_rd_word)
    );

    // Behavioural RAM: registered read, read-before-write, not cleared by rst
    logic [WS-1:0] ram_mem [32];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) ram_mem[i] <= '0;
            ram_rd_word <= '0;
        end else begin
            if (ram_rd_en) ram_rd_word <= ram_mem[ram_rd_addr];
            if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_word;
        end
    end

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    logic [WS-1:0]    model_mem [32];
    logic [IW+WS-1:0] sb [$];
    logic [IW+WS-1:0] sb_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Responses are popped and compared whenever the DUT presents one.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            total_cnt++;
            assert (sb.size() != 0) pass_cnt++;
            else begin
                fail_cnt++;
                $error("FAIL rd_unexpected: observed rd_valid=1 id=%0d required no response", rd_id);
            end
            if (sb.size() != 0) begin
                sb_e = sb.pop_front();
                chk("rd_id", 32'(rd_id), 32'(sb_e[IW+WS-1:WS]));
                chk("rd_data", 32'(rd_data), 32'(sb_e[WS-1:0]));
            end
        end
    end

    task automatic step(input logic [NR-1:0] wreq, input logic [NR-1:0] rreq,
                        input logic [NR-1:0] ewg, input logic [NR-1:0] erg, input bit push);
        int wi, ri;
        logic [WS-1:0] exp_d;
        @(posedge clk);
        #1;
        wr_req = wreq;
        rd_req = rreq;
        #1;
        wi = oh_idx(ewg);
        ri = oh_idx(erg);
        chk("wr_gnt", 32'(wr_gnt), 32'(ewg));
        chk("rd_gnt", 32'(rd_gnt), 32'(erg));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(|ewg));
        chk("ram_rd_en", 32'(ram_rd_en), 32'(|erg));
        if (|ewg) begin
            chk("ram_wr_addr", 32'(ram_wr_addr), 32'(wr_addr[wi]));
            chk("ram_wr_word", 32'(ram_wr_word), 32'(wr_word[wi]));
        end else begin
            chk("ram_wr_addr_idle", 32'(ram_wr_addr), 32'h0);
            chk("ram_wr_word_idle", 32'(ram_wr_word), 32'h0);
        end
        if (|erg) begin
            chk("ram_rd_addr", 32'(ram_rd_addr), 32'(rd_addr[ri]));
            if (push) begin
                exp_d = model_mem[rd_addr[ri]];
`ifdef RAM_ARB_WR_BYPASS_EN
                if ((|ewg) && wr_addr[wi] == rd_addr[ri]) exp_d = wr_word[wi];
`endif
                sb.push_back({IW'(ri), exp_d});
            end
        end
        if (|ewg) model_mem[wr_addr[wi]] = wr_word[wi];
    endtask

    initial begin
        wr_req = '0;
        rd_req = '0;
        for (int i = 0; i < NR; i++) begin
            wr_addr[i] = '0;
            rd_addr[i] = '0;
            wr_word[i] = '0;
        end
        for (int i = 0; i < 32; i++) model_mem[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_id", 32'(rd_id), 32'h0);
        chk("rst_wr_gnt", 32'(wr_gnt), 32'h0);
        chk("rst_rd_gnt", 32'(rd_gnt), 32'h0);
        chk("rst_ram_wr_en", 32'(ram_wr_en), 32'h0);
        rst = 1'b0;
        mem_clr = 1'b0;

        // Read requesters 1 and 2 alternate
        rd_addr[1] = 5'd1;
        rd_addr[2] = 5'd2;
        step(4'b0000, 4'b0110, 4'b0000, 4'b0010, 1'b1);
        step(4'b0000, 4'b0110, 4'b0000, 4'b0100, 1'b1);
        step(4'b0000, 4'b0110, 4'b0000, 4'b0010, 1'b1);

        // All writers for 8 cycles
        for (int i = 0; i < NR; i++) begin
            wr_addr[i] = AW'(10 + i);
            wr_word[i] = WS'(16'h1000 + i);
        end
        for (int r = 0; r < 2; r++) begin
            step(4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b1);
            step(4'b1111, 4'b0000, 4'b0010, 4'b0000, 1'b1);
            step(4'b1111, 4'b0000, 4'b0100, 4'b0000, 1'b1);
            step(4'b1111, 4'b0000, 4'b1000, 4'b0000, 1'b1);
        end

        // Write then read back on the next cycle
        wr_addr[0] = 5'd3;
        wr_word[0] = 16'hBEEF;
        rd_addr[2] = 5'd3;
        step(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1);
        step(4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b1);

        // Same-cycle write and read collision on addr 7
        wr_addr[1] = 5'd7;
        wr_word[1] = 16'h0AAA;
        step(4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b1);
        wr_addr[2] = 5'd7;
        wr_word[2] = 16'h1234;
        rd_addr[3] = 5'd7;
        step(4'b0100, 4'b1000, 4'b0100, 4'b1000, 1'b1);

        // Requester 1 withdraws while 0 is served
        rd_addr[0] = 5'd3;
        step(4'b0000, 4'b0011, 4'b0000, 4'b0001, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Reset right after a read grant discards the response
        rd_addr[2] = 5'd7;
        step(4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd_req = '0;
        #1;
        chk("midrst_rd_valid", 32'(rd_valid), 32'h0);
        chk("midrst_rd_id", 32'(rd_id), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_hold_rd_valid", 32'(rd_valid), 32'h0);
        rst = 1'b0;
        step(4'b1010, 4'b1100, 4'b0010, 4'b0100, 1'b1);

        repeat (3) step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
